// File: rtl/wshb_mire.sv
// Wishbone write master that paints one HDISP x VDISP RGB565 test pattern into the
// framebuffer, releasing the bus for one cycle after every BURST writes.
module wshb_mire #(
    parameter int unsigned HDISP = 640,
    parameter int unsigned VDISP = 480,
    parameter logic [31:0] BASE  = 32'h0,
    parameter int unsigned BURST = 64
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] adr,
    output logic [15:0] dat_ms,
    output logic [1:0]  sel,
    output logic        we,
    output logic        stb,
    output logic        cyc,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    input  logic        ack
);

    // x must reach bit 8 for the grey ramp and y bit 4 for the checkerboard
    localparam int unsigned XW   = ($clog2(HDISP) > 9) ? $clog2(HDISP) : 9;
    localparam int unsigned YW   = ($clog2(VDISP) > 5) ? $clog2(VDISP) : 5;
    localparam int unsigned NBAR = HDISP / 8;
    localparam int unsigned BCW  = ($clog2(NBAR) > 1) ? $clog2(NBAR) : 1;
    localparam int unsigned KW   = ($clog2(BURST) > 1) ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, YIELD} state_t;

    state_t          state, state_n;
    logic [XW-1:0]   x, x_n, x_step;
    logic [YW-1:0]   y, y_n, y_step;
    logic [2:0]      bar, bar_n, bar_step;
    logic [BCW-1:0]  bar_cnt, bcnt_n, bcnt_step;
    logic [KW-1:0]   burst_cnt, burst_n;
    logic [1:0]      mode_q, mode_n;
    logic [31:0]     adr_n;
    logic [15:0]     dat_n, pix;
    logic            cyc_n, stb_n, done_n, busy_n, load, last_pix;
    logic [4:0]      v;

    assign sel = 2'b11;
    assign we  = 1'b1;
    assign cti = 3'b000;
    assign bte = 2'b00;

    assign last_pix = (x == XW'(HDISP - 1)) && (y == YW'(VDISP - 1));

    // Raster successor of the current pixel, including the colour-bar counters
    always_comb begin
        x_step    = x + XW'(1);
        y_step    = y;
        bar_step  = bar;
        bcnt_step = bar_cnt + BCW'(1);
        if (x == XW'(HDISP - 1)) begin
            x_step    = '0;
            y_step    = y + YW'(1);
            bar_step  = '0;
            bcnt_step = '0;
        end else if (bar_cnt == BCW'(NBAR - 1)) begin
            bar_step  = bar + 3'd1;
            bcnt_step = '0;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        bar_n   = bar;
        bcnt_n  = bar_cnt;
        burst_n = burst_cnt;
        mode_n  = mode_q;
        adr_n   = adr;
        load    = 1'b0;
        cyc_n   = 1'b0;
        stb_n   = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = WRITE;
                    mode_n  = mode;
                    x_n     = '0;
                    y_n     = '0;
                    bar_n   = '0;
                    bcnt_n  = '0;
                    burst_n = '0;
                    adr_n   = BASE;
                    load    = 1'b1;
                    cyc_n   = 1'b1;
                    stb_n   = 1'b1;
                end
            end
            WRITE: begin
                cyc_n = 1'b1;
                stb_n = 1'b1;
                if (ack) begin
                    if (last_pix) begin
                        state_n = IDLE;
                        cyc_n   = 1'b0;
                        stb_n   = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        x_n    = x_step;
                        y_n    = y_step;
                        bar_n  = bar_step;
                        bcnt_n = bcnt_step;
                        adr_n  = adr + 32'd2;
                        load   = 1'b1;
                        if (burst_cnt == KW'(BURST - 1)) begin
                            state_n = YIELD;
                            burst_n = '0;
                            cyc_n   = 1'b0;
                            stb_n   = 1'b0;
                        end else begin
                            burst_n = burst_cnt + KW'(1);
                        end
                    end
                end
            end
            YIELD: begin
                state_n = WRITE;
                cyc_n   = 1'b1;
                stb_n   = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // Pattern value for the pixel about to be presented
    always_comb begin
        v = x_n[8:4];
        case (mode_n)
            2'd0: begin
                case (bar_n)
                    3'd0:    pix = 16'hFFFF;
                    3'd1:    pix = 16'hFFE0;
                    3'd2:    pix = 16'h07FF;
                    3'd3:    pix = 16'h07E0;
                    3'd4:    pix = 16'hF81F;
                    3'd5:    pix = 16'hF800;
                    3'd6:    pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            end
            2'd1:    pix = (x_n[4] ^ y_n[4]) ? 16'hFFFF : 16'h0000;
            2'd2:    pix = {v, v, v[4], v};
            default: pix = 16'hFFFF;
        endcase
        dat_n = load ? pix : dat_ms;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            bar       <= '0;
            bar_cnt   <= '0;
            burst_cnt <= '0;
            mode_q    <= '0;
            adr       <= BASE;
            dat_ms    <= '0;
            cyc       <= 1'b0;
            stb       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            x         <= x_n;
            y         <= y_n;
            bar       <= bar_n;
            bar_cnt   <= bcnt_n;
            burst_cnt <= burst_n;
            mode_q    <= mode_n;
            adr       <= adr_n;
            dat_ms    <= dat_n;
            cyc       <= cyc_n;
            stb       <= stb_n;
            done      <= done_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_wshb_mire.sv
// Directed bench for wshb_mire: colour bars, checkerboard with random ack, grey ramp,
// ignored restart, mid-frame reset and back-to-back frames.
module tb_wshb_mire;

    logic clk;
    int   total = 0;
    int   bad   = 0;
    logic [15:0] bars [8];

    logic        nrst0, start0, ack0, busy0, done0, we0, stb0, cyc0;
    logic [1:0]  mode0, sel0, bte0;
    logic [2:0]  cti0;
    logic [31:0] adr0;
    logic [15:0] dat0;

    logic        nrst1, start1, ack1, busy1, done1, we1, stb1, cyc1;
    logic [1:0]  mode1, sel1, bte1;
    logic [2:0]  cti1;
    logic [31:0] adr1;
    logic [15:0] dat1;

    logic        nrst2, start2, ack2, busy2, done2, we2, stb2, cyc2;
    logic [1:0]  mode2, sel2, bte2;
    logic [2:0]  cti2;
    logic [31:0] adr2;
    logic [15:0] dat2;

    wshb_mire #(.HDISP(16), .VDISP(4), .BASE(32'h100), .BURST(8)) dut0 (
        .clk(clk), .nrst(nrst0), .start(start0), .mode(mode0), .busy(busy0), .done(done0),
        .adr(adr0), .dat_ms(dat0), .sel(sel0), .we(we0), .stb(stb0), .cyc(cyc0),
        .cti(cti0), .bte(bte0), .ack(ack0));

    wshb_mire #(.HDISP(32), .VDISP(32), .BASE(32'h100), .BURST(8)) dut1 (
        .clk(clk), .nrst(nrst1), .start(start1), .mode(mode1), .busy(busy1), .done(done1),
        .adr(adr1), .dat_ms(dat1), .sel(sel1), .we(we1), .stb(stb1), .cyc(cyc1),
        .cti(cti1), .bte(bte1), .ack(ack1));

    wshb_mire dut2 (
        .clk(clk), .nrst(nrst2), .start(start2), .mode(mode2), .busy(busy2), .done(done2),
        .adr(adr2), .dat_ms(dat2), .sel(sel2), .we(we2), .stb(stb2), .cyc(cyc2),
        .cti(cti2), .bte(bte2), .ack(ack2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One 16x4 colour-bar frame on dut0 with ack held high
    task automatic frame0(input bit do_start, input bit hold, input int restart_at);
        if (do_start) begin
            mode0  = 2'd0;
            start0 = 1'b1;
            @(negedge clk);
            if (!hold) start0 = 1'b0;
        end
        for (int n = 0; n < 64; n++) begin
            chk("f0 cyc", cyc0, 1);
            chk("f0 stb", stb0, 1);
            chk("f0 busy", busy0, 1);
            chk("f0 adr", adr0, 32'h100 + 32'(2 * n));
            chk("f0 dat", {16'h0, dat0}, {16'h0, bars[(n % 16) / 2]});
            if (restart_at >= 0 && n == restart_at) begin
                start0 = 1'b1;
                mode0  = 2'd3;
            end else if (restart_at >= 0 && n == restart_at + 1) begin
                start0 = 1'b0;
            end
            @(negedge clk);
            if (n % 8 == 7 && n != 63) begin
                chk("f0 yield cyc", cyc0, 0);
                chk("f0 yield busy", busy0, 1);
                @(negedge clk);
            end
        end
        chk("f0 done", done0, 1);
        chk("f0 busy end", busy0, 0);
        chk("f0 cyc end", cyc0, 0);
        @(negedge clk);
        chk("f0 done pulse", done0, 0);
        chk("f0 next cyc", cyc0, {31'h0, hold});
        if (hold) chk("f0 restart adr", adr0, 32'h100);
    endtask

    initial begin
        int cnt, n, xx, yy;
        logic        pend;
        logic [31:0] padr;
        logic [15:0] pdat;
        logic [15:0] exp_px;

        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        nrst0 = 1'b0; start0 = 1'b0; mode0 = 2'd0; ack0 = 1'b0;
        nrst1 = 1'b0; start1 = 1'b0; mode1 = 2'd0; ack1 = 1'b0;
        nrst2 = 1'b0; start2 = 1'b0; mode2 = 2'd0; ack2 = 1'b0;
        #12;
        chk("rst cyc", cyc0, 0);
        chk("rst stb", stb0, 0);
        chk("rst busy", busy0, 0);
        chk("rst done", done0, 0);
        chk("rst adr", adr0, 32'h100);
        chk("rst dat", {16'h0, dat0}, 32'h0);
        @(negedge clk);
        nrst0 = 1'b1; nrst1 = 1'b1; nrst2 = 1'b1;
        ack0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle stray ack cyc", cyc0, 0);
        chk("idle stray ack busy", busy0, 0);

        // Colour bars, then a frame with an ignored restart in mode 3
        frame0(1'b1, 1'b0, -1);
        chk("const sel", {30'h0, sel0}, 32'h3);
        chk("const we", we0, 1);
        chk("const cti", {29'h0, cti0}, 32'h0);
        chk("const bte", {30'h0, bte0}, 32'h0);
        frame0(1'b1, 1'b0, 10);

        // Reset during write #20 while it is waiting for ack
        mode0 = 2'd0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cnt = 0;
        for (int c = 0; c < 60 && cnt < 20; c++) begin
            if (cyc0 && stb0) cnt++;
            @(negedge clk);
        end
        chk("abort reach", cnt, 20);
        ack0 = 1'b0;
        @(negedge clk);
        chk("abort hold stb", stb0, 1);
        chk("abort hold adr", adr0, 32'h128);
        chk("abort hold dat", {16'h0, dat0}, {16'h0, bars[2]});
        #2 nrst0 = 1'b0;
        #1;
        chk("abort cyc", cyc0, 0);
        chk("abort stb", stb0, 0);
        chk("abort busy", busy0, 0);
        @(negedge clk);
        chk("abort no done", done0, 0);
        nrst0 = 1'b1;
        ack0  = 1'b1;
        @(negedge clk);
        chk("abort idle cyc", cyc0, 0);
        chk("abort idle done", done0, 0);
        frame0(1'b1, 1'b0, -1);

        // start held high: frames run back to back
        frame0(1'b1, 1'b1, -1);
        frame0(1'b0, 1'b1, -1);
        start0 = 1'b0;
        nrst0  = 1'b0;

        // 32x32 checkerboard with ~30% ack rate
        mode1  = 2'd1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        pend = 1'b0;
        padr = '0;
        pdat = '0;
        for (int c = 0; c < 20000 && !done1; c++) begin
            if (pend) begin
                chk("d1 adr stable", adr1, padr);
                chk("d1 dat stable", {16'h0, dat1}, {16'h0, pdat});
            end
            ack1 = ($urandom_range(0, 9) < 3);
            if (stb1 && ack1) begin
                xx = n % 32;
                yy = n / 32;
                exp_px = ((((xx >> 4) & 1) ^ ((yy >> 4) & 1)) != 0) ? 16'hFFFF : 16'h0000;
                chk("d1 adr", adr1, 32'h100 + 32'(2 * n));
                chk("d1 dat", {16'h0, dat1}, {16'h0, exp_px});
                n++;
            end
            pend = stb1 && !ack1;
            padr = adr1;
            pdat = dat1;
            @(negedge clk);
        end
        chk("d1 done", done1, 1);
        chk("d1 writes", n, 1024);
        nrst1 = 1'b0;

        // Grey ramp on the default 640-wide geometry, first line only
        ack2   = 1'b1;
        mode2  = 2'd2;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        for (int c = 0; c < 700 && n <= 496; c++) begin
            if (stb2) begin
                if (n < 16)   chk("d2 ramp low", {16'h0, dat2}, 32'h0000);
                if (n == 16)  chk("d2 ramp x16", {16'h0, dat2}, 32'h0841);
                if (n == 496) chk("d2 ramp x496", {16'h0, dat2}, 32'hFFFF);
                if (n == 496) chk("d2 adr x496", adr2, 32'h3E0);
                n++;
            end
            @(negedge clk);
        end
        chk("d2 reach", n, 497);
        nrst2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
